// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask registers, single-source req/ack/eoi handshake to CP0.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; default build is fixed priority (lowest index wins).
module irq_ctrl #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] dev_break,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             irq_eoi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SERV = 2'd2;

  logic [1:0]       state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] brk_q;
  logic [1:0]       ctrl;

  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] pend_next;
  logic [ID_W-1:0]  win;
  logic             any_act;
  logic             cur_act;
  logic             take_ack;
  logic             wr_mask;
  logic             wr_pend;
  logic             wr_ctrl;
  logic             wd_unused;

  function automatic logic [ID_W-1:0] first_set(input logic [N_SRC-1:0] vec);
    logic [ID_W-1:0] pos;
    logic            found;
    pos   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!found && vec[i]) begin
        pos   = ID_W'(i);
        found = 1'b1;
      end
    end
    return pos;
  endfunction

  assign wr_mask   = we && (addr == 2'd0);
  assign wr_pend   = we && (addr == 2'd1);
  assign wr_ctrl   = we && (addr == 2'd3);
  assign wd_unused = ^wd[31:N_SRC];

  assign active   = pend & mask & {N_SRC{ctrl[0]}};
  assign any_act  = |active;
  assign cur_act  = active[irq_id];
  assign take_ack = (state == REQ) && irq_ack;
  assign rise     = dev_break & ~brk_q;
  assign w1c      = wr_pend ? wd[N_SRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      ack_clr[i] = take_ack && (irq_id == ID_W'(i));
    end
  end

  // Edge mode: a rising edge in the same cycle beats both W1C and the ack clear.
  assign pend_next = ctrl[1] ? ((pend & ~w1c & ~ack_clr) | rise) : dev_break;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]      ptr;
  logic [2*N_SRC-1:0]   dbl;
  logic [N_SRC-1:0]     rot;
  logic [ID_W-1:0]      rpos;
  logic [ID_W:0]        rsum;

  // Rotate so the search starts at ptr, then map the fixed-priority hit back.
  always_comb begin
    dbl  = {active, active} >> ptr;
    rot  = dbl[N_SRC-1:0];
    rpos = first_set(rot);
    rsum = {1'b0, ptr} + {1'b0, rpos};
    if (rsum >= (ID_W+1)'(N_SRC)) begin
      rsum = rsum - (ID_W+1)'(N_SRC);
    end
    win = ID_W'(rsum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (take_ack) begin
      ptr <= (irq_id == ID_W'(N_SRC-1)) ? '0 : irq_id + 1'b1;
    end
  end
`else
  assign win = first_set(active);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mask    <= '0;
      pend    <= '0;
      brk_q   <= '0;
      ctrl    <= '0;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      brk_q <= dev_break;
      pend  <= pend_next;
      if (wr_mask) mask <= wd[N_SRC-1:0];
      if (wr_ctrl) ctrl <= wd[1:0];
      case (state)
        IDLE: begin
          if (any_act) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_id  <= win;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERV;
            irq_req <= 1'b0;
          end else if (!cur_act) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        SERV: begin
          if (irq_eoi) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: rd[N_SRC-1:0] = mask;
      2'd1: rd[N_SRC-1:0] = pend;
      2'd2: begin
        rd[ID_W-1:0] = irq_id;
        rd[8]        = irq_req;
        rd[9]        = (state == SERV);
      end
      default: rd[1:0] = ctrl;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected reads and grants, a negedge monitor checks them.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  dev_break;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;
  logic        irq_eoi;

  irq_ctrl #(.N_SRC(6), .ID_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_break (dev_break),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t rq[$];
  int      gq[$];
  logic    chk;
  logic    done;
  int      total;
  int      bad;

  task automatic tick();
    @(posedge clk);
    #1;
    we      = 1'b0;
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    chk     = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    wd   = d;
    tick();
  endtask

  // Arms a read check for the current cycle; the caller advances the clock.
  task automatic expect_rd(input logic [1:0] a, input logic [31:0] e, input string n);
    rd_exp_t item;
    item.name = n;
    item.exp  = e;
    addr = a;
    chk  = 1'b1;
    rq.push_back(item);
  endtask

  // Monitor: owns all counters and the summary line.
  logic req_q = 1'b0;
  int   cycles = 0;
  always @(negedge clk) begin
    rd_exp_t item;
    int      gid;
    cycles = cycles + 1;
    if (chk) begin
      total = total + 1;
      if (rq.size() == 0) begin
        bad = bad + 1;
        $display("FAIL rd_nothing_expected: got rd=%h want a queued expectation", rd);
      end else begin
        item = rq.pop_front();
        if (rd !== item.exp) begin
          bad = bad + 1;
          $display("FAIL %s: got rd=%h want %h", item.name, rd, item.exp);
        end
      end
    end
    if (irq_req === 1'b1 && req_q === 1'b0) begin
      total = total + 1;
      if (gq.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_grant: got irq_id=%0d want no request", irq_id);
      end else begin
        gid = gq.pop_front();
        if (irq_id !== 3'(gid)) begin
          bad = bad + 1;
          $display("FAIL grant_id: got irq_id=%0d want %0d", irq_id, gid);
        end
      end
    end
    req_q = irq_req;
    if (done || cycles > 5000) begin
      if (!done) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL timeout: got %0d cycles want stimulus complete", cycles);
      end
      total = total + 1;
      if (gq.size() != 0 || rq.size() != 0) begin
        bad = bad + 1;
        $display("FAIL leftover: got %0d grants %0d reads outstanding want 0 0", gq.size(), rq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  int p1;
  int p2;
  int lvl_g[4];

  initial begin
    total     = 0;
    bad       = 0;
    done      = 1'b0;
    chk       = 1'b0;
    reset     = 1'b1;
    dev_break = '0;
    we        = 1'b0;
    addr      = '0;
    wd        = '0;
    irq_ack   = 1'b0;
    irq_eoi   = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
    p1 = 2; p2 = 1;
    lvl_g = '{0, 1, 0, 1};
`else
    p1 = 1; p2 = 2;
    lvl_g = '{0, 0, 0, 0};
`endif
    tick();
    tick();
    reset = 1'b0;

    // Reset values at every address
    for (int unsigned a = 0; a < 4; a++) begin
      expect_rd(2'(a), 32'h0, "reset_rd");
      tick();
    end

    // Edge path on dev_break[1]
    wr(2'd3, 32'h3);
    wr(2'd0, 32'h3);
    dev_break = 6'b000010;
    tick();
    dev_break = '0;
    expect_rd(2'd1, 32'h2, "edge_pend");
    gq.push_back(1);
    tick();
    expect_rd(2'd2, 32'h101, "edge_stat_req");
    tick();
    irq_ack = 1'b1;
    tick();
    expect_rd(2'd2, 32'h201, "ack_stat_serv");
    tick();
    expect_rd(2'd1, 32'h0, "ack_pend_clr");
    tick();
    irq_eoi = 1'b1;
    tick();
    expect_rd(2'd2, 32'h001, "eoi_stat_idle");
    tick();

    // Priority with two pending sources
    wr(2'd0, 32'h3F);
    dev_break = 6'b000110;
    tick();
    dev_break = '0;
    gq.push_back(p1);
    tick();
    irq_ack = 1'b1;
    tick();
    irq_eoi = 1'b1;
    tick();
    gq.push_back(p2);
    tick();
    expect_rd(2'd2, 32'h100 | 32'(p2), "prio_stat2");
    irq_ack = 1'b1;
    tick();
    irq_eoi = 1'b1;
    tick();
    expect_rd(2'd1, 32'h0, "prio_pend_empty");
    tick();

    // Level mode, bits 0 and 1 held through ack/eoi
    wr(2'd3, 32'h1);
    dev_break = 6'b000011;
    tick();
    for (int unsigned k = 0; k < 4; k++) begin
      gq.push_back(lvl_g[k]);
      tick();
      expect_rd(2'd1, 32'h3, "lvl_pend");
      irq_ack = 1'b1;
      tick();
      irq_eoi = 1'b1;
      if (k == 3) dev_break = '0;
      tick();
    end
    expect_rd(2'd1, 32'h0, "lvl_drop");
    tick();

    // Withdraw by masking while in REQ
    wr(2'd3, 32'h3);
    dev_break = 6'b000001;
    tick();
    dev_break = '0;
    gq.push_back(0);
    tick();
    wr(2'd0, 32'h0);
    expect_rd(2'd2, 32'h100, "wd_still_req");
    tick();
    expect_rd(2'd2, 32'h000, "wd_dropped");
    irq_ack = 1'b1;
    tick();
    expect_rd(2'd2, 32'h000, "wd_ack_ignored");
    tick();
    expect_rd(2'd1, 32'h1, "wd_pend_held");
    tick();
    wr(2'd1, 32'h1);

    // Edge rise and W1C on the same bit
    we        = 1'b1;
    addr      = 2'd1;
    wd        = 32'h1;
    dev_break = 6'b000001;
    tick();
    dev_break = '0;
    expect_rd(2'd1, 32'h1, "coll_set_wins");
    tick();

    // Reset while in service
    wr(2'd0, 32'h1);
    gq.push_back(0);
    tick();
    irq_ack = 1'b1;
    tick();
    expect_rd(2'd2, 32'h200, "pre_reset_serv");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int unsigned a = 0; a < 4; a++) begin
      expect_rd(2'(a), 32'h0, "serv_reset_rd");
      tick();
    end

    done = 1'b1;
  end

endmodule
